dcache_tag_array: RTL and testbench

Per-set tag/valid storage and victim allocator for the L1 data cache, sitting directly upstream of the tag comparator in the tag-access path. It accepts probe requests, reads the addressed set, and presents registered tags, per-way valids and the pipe tag one cycle later for combinational hit check. It also services miss allocations with invalid-first / round-robin victim selection and reports evictions. A flush FSM invalidates every set, one set per cycle.

---
 rtl/dcache_tag_array.sv | 134 +++++++++++++
 tb/tb_dcache_tag_array.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_tag_array.sv
// rtl/dcache_tag_array.sv - L1 dcache tag/valid storage with round-robin victim allocation and flush
module dcache_tag_array #(
    parameter int NUM_SET  = 16,
    parameter int NUM_WAY  = 4,
    parameter int TAG_BITS = 8,
    parameter int SET_BITS = $clog2(NUM_SET),
    parameter int WAY_BITS = $clog2(NUM_WAY)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         probe_valid_i,
    output logic                         probe_ready_o,
    input  logic [SET_BITS-1:0]          probe_setidx_i,
    input  logic [TAG_BITS-1:0]          probe_tag_i,
    output logic                         probe_valid_o,
    output logic [TAG_BITS*NUM_WAY-1:0]  tag_of_set_o,
    output logic [NUM_WAY-1:0]           valid_of_way_o,
    output logic [TAG_BITS-1:0]          tag_from_pipe_o,
    output logic [SET_BITS-1:0]          setidx_o,
    input  logic                         alloc_valid_i,
    output logic                         alloc_ready_o,
    input  logic [SET_BITS-1:0]          alloc_setidx_i,
    input  logic [TAG_BITS-1:0]          alloc_tag_i,
    output logic                         alloc_done_o,
    output logic [NUM_WAY-1:0]           alloc_way_o,
    output logic                         alloc_evict_valid_o,
    output logic [TAG_BITS-1:0]          alloc_evict_tag_o,
    input  logic                         flush_i,
    output logic                         flush_busy_o,
    output logic                         flush_done_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t              state;
    logic [SET_BITS-1:0] flush_cnt;
    logic [TAG_BITS-1:0] tag_q   [NUM_SET][NUM_WAY];
    logic [NUM_WAY-1:0]  valid_q [NUM_SET];
    logic [WAY_BITS-1:0] rr_ptr  [NUM_SET];

    logic                alloc_fire;
    logic                probe_fire;
    logic [NUM_WAY-1:0]  alloc_set_valid;
    logic [WAY_BITS-1:0] victim;
    logic                victim_is_ptr;

    assign alloc_ready_o   = (state == IDLE) && !flush_i;
    assign probe_ready_o   = alloc_ready_o && !alloc_valid_i;
    assign alloc_fire      = alloc_valid_i && alloc_ready_o;
    assign probe_fire      = probe_valid_i && probe_ready_o;
    assign flush_busy_o    = (state == FLUSH);
    assign alloc_set_valid = valid_q[alloc_setidx_i];

    // Lowest invalid way wins; the round-robin pointer is only consulted for a full set.
    always_comb begin
        victim        = rr_ptr[alloc_setidx_i];
        victim_is_ptr = 1'b1;
        for (int i = NUM_WAY - 1; i >= 0; i--) begin
            if (!alloc_set_valid[i]) begin
                victim        = WAY_BITS'(i);
                victim_is_ptr = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            tag_q[alloc_setidx_i][victim] <= alloc_tag_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            flush_cnt           <= '0;
            probe_valid_o       <= 1'b0;
            tag_of_set_o        <= '0;
            valid_of_way_o      <= '0;
            tag_from_pipe_o     <= '0;
            setidx_o            <= '0;
            alloc_done_o        <= 1'b0;
            alloc_way_o         <= '0;
            alloc_evict_valid_o <= 1'b0;
            alloc_evict_tag_o   <= '0;
            flush_done_o        <= 1'b0;
            for (int s = 0; s < NUM_SET; s++) begin
                valid_q[s] <= '0;
                rr_ptr[s]  <= '0;
            end
        end else begin
            probe_valid_o <= 1'b0;
            alloc_done_o  <= 1'b0;
            flush_done_o  <= 1'b0;
            if (state == IDLE) begin
                if (flush_i) begin
                    state     <= FLUSH;
                    flush_cnt <= '0;
                end else begin
                    if (alloc_fire) begin
                        valid_q[alloc_setidx_i][victim] <= 1'b1;
                        if (victim_is_ptr) begin
                            rr_ptr[alloc_setidx_i] <=
                                (rr_ptr[alloc_setidx_i] == WAY_BITS'(NUM_WAY - 1)) ?
                                '0 : rr_ptr[alloc_setidx_i] + 1'b1;
                        end
                        alloc_done_o        <= 1'b1;
                        alloc_way_o         <= NUM_WAY'(1) << victim;
                        alloc_evict_valid_o <= victim_is_ptr;
                        alloc_evict_tag_o   <= victim_is_ptr ?
                                               tag_q[alloc_setidx_i][victim] : '0;
                    end
                    if (probe_fire) begin
                        probe_valid_o   <= 1'b1;
                        valid_of_way_o  <= valid_q[probe_setidx_i];
                        tag_from_pipe_o <= probe_tag_i;
                        setidx_o        <= probe_setidx_i;
                        for (int i = 0; i < NUM_WAY; i++) begin
                            tag_of_set_o[TAG_BITS*i +: TAG_BITS] <= tag_q[probe_setidx_i][i];
                        end
                    end
                end
            end else begin
                valid_q[flush_cnt] <= '0;
                rr_ptr[flush_cnt]  <= '0;
                flush_cnt          <= flush_cnt + 1'b1;
                if (flush_cnt == SET_BITS'(NUM_SET - 1)) begin
                    state        <= IDLE;
                    flush_done_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_tag_array.sv
// tb/tb_dcache_tag_array.sv - table-driven self-checking bench for dcache_tag_array
module tb_dcache_tag_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        probe_valid_i;
    logic        probe_ready_o;
    logic [3:0]  probe_setidx_i;
    logic [7:0]  probe_tag_i;
    logic        probe_valid_o;
    logic [31:0] tag_of_set_o;
    logic [3:0]  valid_of_way_o;
    logic [7:0]  tag_from_pipe_o;
    logic [3:0]  setidx_o;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [3:0]  alloc_setidx_i;
    logic [7:0]  alloc_tag_i;
    logic        alloc_done_o;
    logic [3:0]  alloc_way_o;
    logic        alloc_evict_valid_o;
    logic [7:0]  alloc_evict_tag_o;
    logic        flush_i;
    logic        flush_busy_o;
    logic        flush_done_o;

    dcache_tag_array dut (
        .clk(clk), .rst(rst),
        .probe_valid_i(probe_valid_i), .probe_ready_o(probe_ready_o),
        .probe_setidx_i(probe_setidx_i), .probe_tag_i(probe_tag_i),
        .probe_valid_o(probe_valid_o), .tag_of_set_o(tag_of_set_o),
        .valid_of_way_o(valid_of_way_o), .tag_from_pipe_o(tag_from_pipe_o),
        .setidx_o(setidx_o),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_setidx_i(alloc_setidx_i), .alloc_tag_i(alloc_tag_i),
        .alloc_done_o(alloc_done_o), .alloc_way_o(alloc_way_o),
        .alloc_evict_valid_o(alloc_evict_valid_o), .alloc_evict_tag_o(alloc_evict_tag_o),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [3:0]  pset;
        logic [7:0]  ptag;
        logic        av;
        logic [3:0]  aset;
        logic [7:0]  atag;
        logic [3:0]  e_vow;
        logic [31:0] e_tags;
        logic [31:0] e_tmask;
        logic [3:0]  e_way;
        logic        e_ev;
        logic [7:0]  e_et;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t pvec(input logic [3:0] s, input logic [7:0] t, input logic [3:0] vow,
                                  input logic [31:0] tags, input logic [31:0] mask);
        vec_t v;
        v = '{pv: 1'b1, pset: s, ptag: t, av: 1'b0, aset: 4'd0, atag: 8'd0, e_vow: vow,
              e_tags: tags, e_tmask: mask, e_way: 4'd0, e_ev: 1'b0, e_et: 8'd0};
        return v;
    endfunction

    function automatic vec_t avec(input logic [3:0] s, input logic [7:0] t, input logic [3:0] way,
                                  input logic ev, input logic [7:0] et);
        vec_t v;
        v = '{pv: 1'b0, pset: 4'd0, ptag: 8'd0, av: 1'b1, aset: s, atag: t, e_vow: 4'd0,
              e_tags: 32'd0, e_tmask: 32'd0, e_way: way, e_ev: ev, e_et: et};
        return v;
    endfunction

    task automatic do_probe(input logic [3:0] s, input logic [3:0] vow);
        probe_valid_i = 1'b1; probe_setidx_i = s; probe_tag_i = 8'hC3;
        #1 chk("seq_probe_ready", probe_ready_o, 1'b1);
        step();
        probe_valid_i = 1'b0;
        chk("seq_probe_valid", probe_valid_o, 1'b1);
        chk("seq_probe_vow", valid_of_way_o, vow);
        chk("seq_probe_set", setidx_o, s);
    endtask

    task automatic do_alloc(input logic [3:0] s, input logic [7:0] t, input logic [3:0] way);
        alloc_valid_i = 1'b1; alloc_setidx_i = s; alloc_tag_i = t;
        #1 chk("seq_alloc_ready", alloc_ready_o, 1'b1);
        step();
        alloc_valid_i = 1'b0;
        chk("seq_alloc_done", alloc_done_o, 1'b1);
        chk("seq_alloc_way", alloc_way_o, way);
        chk("seq_alloc_evict", alloc_evict_valid_o, 1'b0);
    endtask

    initial begin
        int busy_cnt, done_cnt, done_at, rdy_bad;
        vec_t v, both;

        rst = 1'b1;
        probe_valid_i = 1'b0; probe_setidx_i = '0; probe_tag_i = '0;
        alloc_valid_i = 1'b0; alloc_setidx_i = '0; alloc_tag_i = '0;
        flush_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_probe_valid", probe_valid_o, 1'b0);
        chk("rst_alloc_done", alloc_done_o, 1'b0);
        chk("rst_flush_busy", flush_busy_o, 1'b0);
        chk("rst_flush_done", flush_done_o, 1'b0);
        chk("rst_tags", tag_of_set_o, 32'd0);
        chk("rst_vow", valid_of_way_o, 4'd0);
        chk("rst_alloc_way", alloc_way_o, 4'd0);
        chk("rst_probe_ready", probe_ready_o, 1'b1);
        chk("rst_alloc_ready", alloc_ready_o, 1'b1);

        vecs.push_back(pvec(4'd3, 8'h5A, 4'b0000, 32'd0, 32'd0));
        vecs.push_back(avec(4'd3, 8'h11, 4'b0001, 1'b0, 8'h00));
        vecs.push_back(avec(4'd3, 8'h22, 4'b0010, 1'b0, 8'h00));
        vecs.push_back(avec(4'd3, 8'h33, 4'b0100, 1'b0, 8'h00));
        vecs.push_back(avec(4'd3, 8'h44, 4'b1000, 1'b0, 8'h00));
        vecs.push_back(pvec(4'd3, 8'h77, 4'b1111, 32'h44332211, 32'hFFFFFFFF));
        vecs.push_back(avec(4'd3, 8'h55, 4'b0001, 1'b1, 8'h11));
        vecs.push_back(avec(4'd3, 8'h66, 4'b0010, 1'b1, 8'h22));
        vecs.push_back(avec(4'd3, 8'h77, 4'b0100, 1'b1, 8'h33));
        vecs.push_back(avec(4'd3, 8'h88, 4'b1000, 1'b1, 8'h44));
        vecs.push_back(avec(4'd3, 8'h99, 4'b0001, 1'b1, 8'h55));
        both = avec(4'd3, 8'hAA, 4'b0010, 1'b1, 8'h66);
        both.pv = 1'b1; both.pset = 4'd3; both.ptag = 8'h01;
        vecs.push_back(both);
        vecs.push_back(pvec(4'd3, 8'h01, 4'b1111, 32'h8877AA99, 32'hFFFFFFFF));
        vecs.push_back(avec(4'd0, 8'hAB, 4'b0001, 1'b0, 8'h00));
        vecs.push_back(avec(4'd15, 8'hCD, 4'b0001, 1'b0, 8'h00));
        vecs.push_back(pvec(4'd0, 8'h10, 4'b0001, 32'h000000AB, 32'h000000FF));
        vecs.push_back(pvec(4'd15, 8'hF0, 4'b0001, 32'h000000CD, 32'h000000FF));
        v = avec(4'd0, 8'd0, 4'd0, 1'b0, 8'd0);
        v.av = 1'b0;
        vecs.push_back(v);

        foreach (vecs[n]) begin
            v = vecs[n];
            probe_valid_i = v.pv; probe_setidx_i = v.pset; probe_tag_i = v.ptag;
            alloc_valid_i = v.av; alloc_setidx_i = v.aset; alloc_tag_i = v.atag;
            #1;
            chk($sformatf("v%0d_probe_ready", n), probe_ready_o, !v.av);
            chk($sformatf("v%0d_alloc_ready", n), alloc_ready_o, 1'b1);
            step();
            chk($sformatf("v%0d_probe_valid", n), probe_valid_o, v.pv && !v.av);
            chk($sformatf("v%0d_alloc_done", n), alloc_done_o, v.av);
            if (v.pv && !v.av) begin
                chk($sformatf("v%0d_vow", n), valid_of_way_o, v.e_vow);
                chk($sformatf("v%0d_tag_pipe", n), tag_from_pipe_o, v.ptag);
                chk($sformatf("v%0d_setidx", n), setidx_o, v.pset);
                chk($sformatf("v%0d_tags", n), tag_of_set_o & v.e_tmask, v.e_tags);
            end
            if (v.av) begin
                chk($sformatf("v%0d_way", n), alloc_way_o, v.e_way);
                chk($sformatf("v%0d_evict_valid", n), alloc_evict_valid_o, v.e_ev);
                chk($sformatf("v%0d_evict_tag", n), alloc_evict_tag_o, v.e_et);
            end
        end
        probe_valid_i = 1'b0; alloc_valid_i = 1'b0;

        // Full flush: busy window, done pulse position, readies gated, re-flush ignored.
        flush_i = 1'b1;
        #1;
        chk("flush_entry_alloc_ready", alloc_ready_o, 1'b0);
        chk("flush_entry_probe_ready", probe_ready_o, 1'b0);
        step();
        flush_i = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1; rdy_bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (flush_busy_o) begin
                busy_cnt++;
                if (!flush_i && (alloc_ready_o || probe_ready_o)) rdy_bad++;
            end
            if (flush_done_o) begin
                done_cnt++;
                done_at = k;
            end
            flush_i = (k == 3);
            step();
        end
        flush_i = 1'b0;
        chk("flush_busy_cycles", busy_cnt, 16);
        chk("flush_done_pulses", done_cnt, 1);
        chk("flush_done_cycle", done_at, 16);
        chk("flush_ready_gated", rdy_bad, 0);
        do_probe(4'd0, 4'b0000);
        do_probe(4'd15, 4'b0000);
        do_probe(4'd3, 4'b0000);
        do_alloc(4'd15, 8'hE1, 4'b0001);

        // Reset while the flush counter sits at 5; set 10 has not been cleared by the flush yet.
        do_alloc(4'd5, 8'h21, 4'b0001);
        do_alloc(4'd10, 8'h31, 4'b0001);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("midflush_busy_before_rst", flush_busy_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("midflush_busy_after_rst", flush_busy_o, 1'b0);
        chk("midflush_ready_in_rst", alloc_ready_o, 1'b1);
        step();
        rst = 1'b0;
        done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (flush_done_o) done_cnt++;
            if (flush_busy_o) busy_cnt++;
            step();
        end
        chk("midflush_no_done", done_cnt, 0);
        chk("midflush_no_busy", busy_cnt, 0);
        do_probe(4'd10, 4'b0000);
        do_probe(4'd5, 4'b0000);
        do_probe(4'd15, 4'b0000);
        do_alloc(4'd10, 8'h41, 4'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
